// File: rtl/jtbubl_gfx_pkg.sv
// Shared types for the graphics ROM fetch adapter.
// JTBUBL_GFXCACHE2_EN selects a 2-entry LRU cache; otherwise a single entry.
package jtbubl_gfx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } state_t;

  // Tag is kept at a fixed 32-bit width so the struct does not depend on AW.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] data;
  } entry_t;

`ifdef JTBUBL_GFXCACHE2_EN
  localparam int NENTRIES = 2;
`else
  localparam int NENTRIES = 1;
`endif

  localparam int IDXW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

endpackage

// File: rtl/jtbubl_gfx_tagmem.sv
// Cache entries and LRU state: combinational hit/select plus a fill write port.
// JTBUBL_GFXCACHE2_EN enables the second entry and the 1-bit LRU.
module jtbubl_gfx_tagmem
  import jtbubl_gfx_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [AW-2:0] lookup_tag,
  input  logic          touch,
  output logic          hit,
  output logic [31:0]   hit_data,
  input  logic          fill_en,
  input  logic [AW-2:0] fill_tag,
  input  logic [31:0]   fill_data
);

  entry_t              entry_reg [NENTRIES];
  logic [NENTRIES-1:0] match;
  logic [IDXW-1:0]     victim;

  genvar gi;
  generate
    for (gi = 0; gi < NENTRIES; gi++) begin : g_match
      assign match[gi] = entry_reg[gi].valid && (entry_reg[gi].tag == 32'(lookup_tag));
    end
  endgenerate

  assign hit = |match;

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (match[i]) hit_data = entry_reg[i].data;
    end
  end

`ifdef JTBUBL_GFXCACHE2_EN
  logic       lru_reg;  // index of the least recently used entry
  logic [0:0] hit_idx;

  always_comb begin
    hit_idx = 1'b0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (match[i]) hit_idx = 1'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_reg <= 1'b0;
    end else if (fill_en) begin
      lru_reg <= ~lru_reg;
    end else if (touch && hit) begin
      lru_reg <= ~hit_idx[0];
    end
  end

  assign victim = lru_reg;
`else
  wire unused_touch = &{1'b0, touch};
  assign victim = '0;
`endif

  // A flush wins over a same-cycle fill so nothing survives a download.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NENTRIES; i++) begin
      if (rst || flush) begin
        entry_reg[i].valid <= 1'b0;
      end else if (fill_en && (victim == IDXW'(i))) begin
        entry_reg[i] <= '{valid: 1'b1, tag: 32'(fill_tag), data: fill_data};
      end
    end
  end

endmodule

// File: rtl/jtbubl_gfx_fetch.sv
// Graphics ROM fetch adapter: 16-bit level-held video reads to 32-bit SDRAM lines.
// Cache depth follows JTBUBL_GFXCACHE2_EN (see jtbubl_gfx_pkg).
module jtbubl_gfx_fetch
  import jtbubl_gfx_pkg::*;
#(
  parameter int AW       = 18,
  parameter bit LATCH_OK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          gfx_cs,
  input  logic [AW-1:0] gfx_addr,
  output logic [15:0]   gfx_data,
  output logic          gfx_ok,
  output logic          sdram_req,
  output logic [AW-2:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [31:0]   sdram_data
);

  state_t        state_reg;
  logic          req_reg;
  logic          ok_reg;
  logic [15:0]   data_reg;
  logic [AW-1:0] served_reg;
  logic [AW-2:0] line_reg;

  logic          tag_hit;
  logic [31:0]   hit_data;
  logic          hit;
  logic          evaluate;
  logic          fill_en;
  logic [15:0]   sel_word;

  assign evaluate = (state_reg == IDLE) || (state_reg == FILL);
  assign hit      = gfx_cs && tag_hit && !downloading;
  assign fill_en  = (state_reg == WAIT) && sdram_dst;
  assign sel_word = gfx_addr[0] ? hit_data[31:16] : hit_data[15:0];

  jtbubl_gfx_tagmem #(.AW(AW)) u_tagmem (
    .clk        (clk),
    .rst        (rst),
    .flush      (downloading),
    .lookup_tag (gfx_addr[AW-1:1]),
    .touch      (evaluate && hit),
    .hit        (tag_hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_tag   (line_reg),
    .fill_data  (sdram_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      req_reg    <= 1'b0;
      ok_reg     <= 1'b0;
      data_reg   <= '0;
      served_reg <= '0;
      line_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, FILL: begin
          ok_reg    <= hit;
          state_reg <= IDLE;
          if (hit) begin
            data_reg   <= sel_word;
            served_reg <= gfx_addr;
          end
          // FILL only re-evaluates; a miss there restarts from IDLE next cycle.
          if ((state_reg == IDLE) && gfx_cs && !tag_hit && !downloading) begin
            line_reg  <= gfx_addr[AW-1:1];
            req_reg   <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (sdram_dst) state_reg <= FILL;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    if (LATCH_OK) begin : g_latch_ok
      assign gfx_ok = ok_reg && gfx_cs && (gfx_addr == served_reg);
    end else begin : g_raw_ok
      assign gfx_ok = ok_reg;
      wire unused_served = &{1'b0, served_reg};
    end
  endgenerate

  assign gfx_data   = data_reg;
  assign sdram_req  = req_reg;
  assign sdram_addr = line_reg;

endmodule

// File: tb/tb_jtbubl_gfx_fetch.sv
// Self-checking bench for jtbubl_gfx_fetch with an expected-word scoreboard.
module tb_jtbubl_gfx_fetch;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic          gfx_cs;
  logic [AW-1:0] gfx_addr;
  logic [15:0]   gfx_data;
  logic          gfx_ok;
  logic          sdram_req;
  logic [AW-2:0] sdram_addr;
  logic          sdram_ack;
  logic          sdram_dst;
  logic [31:0]   sdram_data;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  bit          two_entries;

  jtbubl_gfx_fetch #(.AW(AW), .LATCH_OK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .gfx_cs      (gfx_cs),
    .gfx_addr    (gfx_addr),
    .gfx_data    (gfx_data),
    .gfx_ok      (gfx_ok),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_dst   (sdram_dst),
    .sdram_data  (sdram_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM content model: line 8 is the documented 0xBEEF1234, the rest hashed.
  function automatic logic [31:0] line_data(input logic [AW-2:0] line);
    logic [31:0] l;
    l = 32'(line);
    if (l == 32'h8) return 32'hBEEF1234;
    return (l * 32'h9E3779B1) ^ 32'h0F0F5A5A;
  endfunction

  function automatic logic [15:0] word_of(input logic [AW-1:0] addr);
    logic [31:0] d;
    d = line_data(addr[AW-1:1]);
    return addr[0] ? d[31:16] : d[15:0];
  endfunction

  task automatic start_read(input logic [AW-1:0] addr);
    gfx_addr = addr;
    gfx_cs   = 1'b1;
    exp_q.push_back(word_of(addr));
  endtask

  task automatic expect_ok(input string tag);
    logic [15:0] exp;
    check({tag, "_ok"}, 32'(gfx_ok), 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, 32'(gfx_data), 32'(exp));
    end
    $display("read %s addr=%05h data=%04h ok=%0d", tag, gfx_addr, gfx_data, gfx_ok);
  endtask

  // Entered at +1 of a request; returns in the FILL cycle.
  task automatic serve(input logic [AW-2:0] line);
    tick();
    check("req_hold", 32'(sdram_req), 32'd1);
    check("addr_hold", 32'(sdram_addr), 32'(line));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_drop", 32'(sdram_req), 32'd0);
    check("addr_wait", 32'(sdram_addr), 32'(line));
    tick();
    tick();
    sdram_dst  = 1'b1;
    sdram_data = line_data(line);
    tick();
    sdram_dst  = 1'b0;
    sdram_data = '0;
    check("fill_ok", 32'(gfx_ok), 32'd0);
  endtask

  task automatic miss_read(input logic [AW-1:0] addr);
    start_read(addr);
    tick();
    check("miss_req", 32'(sdram_req), 32'd1);
    check("miss_addr", 32'(sdram_addr), 32'(addr[AW-1:1]));
    serve(addr[AW-1:1]);
    tick();
    expect_ok("miss");
  endtask

  task automatic hit_read(input logic [AW-1:0] addr);
    start_read(addr);
    tick();
    check("hit_noreq", 32'(sdram_req), 32'd0);
    expect_ok("hit");
  endtask

  task automatic read_cfg(input logic [AW-1:0] addr, input bit hit_two, input bit hit_one);
    if (two_entries ? hit_two : hit_one) hit_read(addr);
    else miss_read(addr);
  endtask

  task automatic drop_cs();
    gfx_cs = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef JTBUBL_GFXCACHE2_EN
    two_entries = 1'b1;
`else
    two_entries = 1'b0;
`endif
    rst = 1'b1; downloading = 1'b0; gfx_cs = 1'b0; gfx_addr = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_ok", 32'(gfx_ok), 32'd0);
    check("rst_data", 32'(gfx_data), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);

    // Cold miss, then the adjacent word of the same line
    miss_read(18'h00010);
    hit_read(18'h00011);
    drop_cs();

    // Replacement order
    miss_read(18'h00200);
    read_cfg(18'h00010, 1'b1, 1'b0);
    miss_read(18'h00400);
    read_cfg(18'h00010, 1'b1, 1'b0);
    miss_read(18'h00200);
    drop_cs();

    // cs drops while waiting for data
    gfx_addr = 18'h01000; gfx_cs = 1'b1;
    tick();
    check("csdrop_req", 32'(sdram_req), 32'd1);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    gfx_cs = 1'b0;
    tick();
    sdram_dst = 1'b1; sdram_data = line_data(17'h00800);
    tick();
    sdram_dst = 1'b0; sdram_data = '0;
    check("csdrop_fill_ok", 32'(gfx_ok), 32'd0);
    tick();
    check("csdrop_ok", 32'(gfx_ok), 32'd0);
    check("csdrop_noreq", 32'(sdram_req), 32'd0);
    hit_read(18'h01000);
    drop_cs();

    // Address changes while the request is pending
    gfx_addr = 18'h02000; gfx_cs = 1'b1;
    tick();
    check("chg_req", 32'(sdram_req), 32'd1);
    check("chg_addr", 32'(sdram_addr), 32'h1000);
    gfx_addr = 18'h00400;
    exp_q.push_back(word_of(18'h00400));
    serve(17'h01000);
    tick();
    check("chg_gap_req", 32'(sdram_req), 32'd0);
    check("chg_gap_ok", 32'(gfx_ok), 32'd0);
    tick();
    check("chg_req2", 32'(sdram_req), 32'd1);
    check("chg_addr2", 32'(sdram_addr), 32'h0200);
    serve(17'h00200);
    tick();
    expect_ok("chg");
    read_cfg(18'h02000, 1'b1, 1'b0);
    drop_cs();

    // Download flushes the cache and blocks requests
    hit_read(18'h02000);
    drop_cs();
    downloading = 1'b1; gfx_cs = 1'b1; gfx_addr = 18'h02000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dl_noreq", 32'(sdram_req), 32'd0);
      check("dl_ok", 32'(gfx_ok), 32'd0);
    end
    downloading = 1'b0;
    exp_q.push_back(word_of(18'h02000));
    tick();
    check("dl_miss", 32'(sdram_req), 32'd1);
    serve(17'h01000);
    tick();
    expect_ok("dl");
    drop_cs();

    // Reset in WAIT with a late data strobe
    hit_read(18'h02000);
    drop_cs();
    gfx_addr = 18'h04000; gfx_cs = 1'b1;
    tick();
    check("rw_req", 32'(sdram_req), 32'd1);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; gfx_cs = 1'b0;
    check("rw_req_clr", 32'(sdram_req), 32'd0);
    check("rw_ok_clr", 32'(gfx_ok), 32'd0);
    tick();
    sdram_dst = 1'b1; sdram_data = line_data(17'h02000);
    tick();
    sdram_dst = 1'b0; sdram_data = '0;
    check("rw_late_req", 32'(sdram_req), 32'd0);
    check("rw_late_ok", 32'(gfx_ok), 32'd0);
    check("rw_data", 32'(gfx_data), 32'd0);
    start_read(18'h02000);
    tick();
    check("rw_flushed", 32'(sdram_req), 32'd1);
    serve(17'h01000);
    tick();
    expect_ok("rw");
    drop_cs();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtbubl_gfx_fetch.md
# jtbubl_gfx_fetch

Graphics ROM fetch adapter between the video block's tile/object read port (`gfx_addr`/`gfx_cs`/`gfx_data`/`gfx_ok`) and an SDRAM bank slot. It converts the video block's level-held 16-bit read requests into 32-bit SDRAM burst requests. A small tag cache absorbs the repeated and adjacent reads of the tile fetcher, so most accesses return in one cycle without an SDRAM round trip.

## Interface
Parameters:
- `AW`, 18, video-side word address width (16-bit words).
- `LATCH_OK`, 1, 1 = `gfx_ok` gated by an address compare; 0 = raw registered flag.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: 48 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `downloading` in 1: ROM download in progress; flushes the cache and holds IDLE.
- `gfx_cs` in 1: video read request, held high until served.
- `gfx_addr` in AW: video word address.
- `gfx_data` out 16: selected half of the cached 32-bit line.
- `gfx_ok` out 1: `gfx_data` valid for the current `gfx_addr`.
- `sdram_req` out 1: SDRAM request, held until `sdram_ack`.
- `sdram_addr` out AW-1: line address, equal to `gfx_addr[AW-1:1]`.
- `sdram_ack` in 1: request accepted (1-cycle pulse).
- `sdram_dst` in 1: read data strobe (1-cycle pulse).
- `sdram_data` in 32: line data. Bits [15:0] are the even word, bits [31:16] the odd word.

## Operation
- Each cache entry holds `valid`, `tag = addr[AW-1:1]` and 32 bits of data. The number of entries is set by the configuration macro.
- A hit requires `gfx_cs` high, a valid entry and a tag equal to `gfx_addr[AW-1:1]`. The output word is selected by `gfx_addr[0]`.
- State machine:
  - IDLE: on a hit, register the selected word, assert ok and stay in IDLE. On a miss, latch the line address and go to REQ.
  - REQ: `sdram_req`=1. On `sdram_ack`, drop req and go to WAIT.
  - WAIT: on `sdram_dst`, write the victim entry (tag, data, valid=1), mark it MRU and go to FILL.
  - FILL: one cycle. Re-evaluate the request as in IDLE, then go to IDLE.
- Replacement: LRU. With one entry, the victim is always entry 0.
- `gfx_ok`: registered flag set on the hit-evaluation cycle. With `LATCH_OK`=1 it is additionally ANDed with `gfx_addr == served_addr && gfx_cs`, so it drops combinationally on an address change or a `cs` drop.
- `gfx_cs` low in REQ or WAIT: the transaction is not aborted. The line is filled, and no ok is raised unless `cs` returns with a matching address.
- Address change during REQ or WAIT: the in-flight line completes and is cached. FILL then re-evaluates the new address and may start another miss.
- `downloading`=1: all valid bits clear every cycle and the FSM is held in IDLE after the current SDRAM transaction completes. `sdram_req` never rises while `downloading` is high.
- A `sdram_dst` outside WAIT is ignored.

## Timing
- Reset values: `sdram_req`=0, `gfx_ok`=0, `gfx_data`=0, all valid=0, LRU=0, state=IDLE, `sdram_addr`=0.
- Hit latency: `gfx_ok` rises the cycle after `gfx_cs`/address is sampled in IDLE.
- Miss latency: `sdram_req` rises 1 cycle after the miss is detected. `gfx_ok` rises 2 cycles after `sdram_dst` (the WAIT→FILL edge, then the FILL evaluation).
- `sdram_addr` is stable from the REQ entry until the WAIT exit.
- A reset during REQ or WAIT returns to IDLE next cycle with `req`=0. The SDRAM controller's late `dst` is ignored by the WAIT-only rule.

## Configuration
- `JTBUBL_GFXCACHE2_EN` defined: 2-entry cache with 1-bit LRU. Two alternating tile/object lines both stay resident.
- Not defined: single entry. The LRU logic is removed and every new line replaces entry 0.

## Structure
- Package `jtbubl_gfx_pkg`: state enum (IDLE, REQ, WAIT, FILL), the cache entry struct (valid, tag, data) and the `NENTRIES` constant derived from the macro.
- Natural sub-module: `jtbubl_gfx_tagmem`. It holds the entries and LRU, and provides a combinational hit/select output plus a fill write port. The FSM stays in the top module.

## Test plan
- Cold miss: after reset, `cs`=1, addr=0x00010. Expect `sdram_req` at +1 with `sdram_addr`=0x0008. With ack at +3 and dst at +6 carrying data=0xBEEF1234, expect `gfx_ok` at +8 with `gfx_data`=0x1234.
- Adjacent hit: follow with addr=0x00011. Expect `gfx_ok` 1 cycle later, `gfx_data`=0xBEEF, and no `sdram_req`.
- LRU, macro on: fill lines 0x0008 and 0x0100, re-read 0x0008, then miss on 0x0200. The line 0x0100 is evicted, so a read of 0x00010 hits and a read of 0x00200 misses. Macro off: the read of 0x00010 misses.
- `cs` drop mid-fetch: drop `cs` in WAIT. Expect the fill to complete, `gfx_ok` to stay 0, and a later read of the same address to hit in 1 cycle.
- Address change mid-fetch: change addr to 0x00400 during REQ. Expect the first line to be cached, a second `sdram_req` for 0x0200 after FILL, and `gfx_ok` only for 0x00400.
- Reset and download: assert `rst` in WAIT and pulse `dst` 2 cycles later. Expect no valid entry and `gfx_ok`=0. Set `downloading`=1 with `cs` high: expect `sdram_req` to stay 0 and the previously cached address to miss after `downloading` falls.
